// File: rtl/pwm_duty_pkg.sv
// pwm_duty_pkg: shared constants for the PWM duty controller.
//   DUTY_MAX / DUTY_W : duty range (0..100 %) and register width
//   SEG_BLANK         : all segments off (active-low)
//   SEG_LUT           : active-low {g,f,e,d,c,b,a} codes for digits 0..9
//   seg_of()          : digit -> segment code, non-decimal input shows blank
package pwm_duty_pkg;

  localparam int         DUTY_MAX  = 100;
  localparam int         DUTY_W    = 7;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Indexed by digit value; entry 9 is listed first (packed MSB).
  localparam logic [9:0][6:0] SEG_LUT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_LUT[d];
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: one BCD digit to a 7-segment display, active-low segments.
//   bcd_i   [3:0] digit 0..9
//   blank_i       force all segments off
//   seg_o   [6:0] {g,f,e,d,c,b,a}, 0 = lit
module seg7_dec
  import pwm_duty_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg_of(bcd_i);

endmodule

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: board-level PWM duty controller.
//   SW[0] enables the output, rising edges on SW[1]/SW[2] step the duty
//   up/down by STEP percent (saturating 0..100). The duty is shown in decimal
//   on HEX2..HEX0 with leading-zero blanking; all digits blank while disabled.
// Ports:
//   clk      system clock (rising edge)
//   rst_n    asynchronous active-low reset
//   SW[2:0]  raw switches: [0]=enable level, [1]=up, [2]=down
//   pwm_out  registered PWM output, period 100*CLK_DIV clk
//   HEX0/1/2 units/tens/hundreds digit, active-low {g,f,e,d,c,b,a}
// Build option:
//   PWM_DEBOUNCE_EN : SW[1]/SW[2] must be stable DEB_CYCLES clocks after
//                     synchronisation before an edge is recognised.
module pwm_duty_ctrl
  import pwm_duty_pkg::*;
#(
  parameter int STEP        = 10,
  parameter int CLK_DIV     = 1,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] SW,
  output logic       pwm_out,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2
);

  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);
  localparam int                DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || CLK_DIV < 1) begin : g_bad_param
    $error("pwm_duty_ctrl: illegal parameter value");
  end

  // ---------------- switch synchronizer ----------------
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  sw_s;
  logic                        en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], SW};
  end

  assign sw_s = sync_q[SYNC_STAGES-1];
  assign en   = sw_s[0];

  // ---------------- optional debounce ----------------
  // lvl[0] = up switch level, lvl[1] = down switch level
  logic [1:0] lvl;

`ifdef PWM_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  logic [1:0][DEB_W-1:0] deb_cnt_q;
  logic [1:0]            deb_q;

  // Counter runs only while the synced level disagrees with the debounced
  // one; any agreement restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      deb_q     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sw_s[i+1] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_q[i]     <= sw_s[i+1];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = sw_s[2:1];
`endif

  // ---------------- edge detect ----------------
  logic [1:0] lvl_q;
  logic [1:0] rise;
  logic       up, dn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= '0;
    else        lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;
  // Simultaneous up and down cancel out.
  assign up   = en & rise[0] & ~rise[1];
  assign dn   = en & rise[1] & ~rise[0];

  // ---------------- duty register ----------------
  logic [DUTY_W-1:0] duty_q, duty_d;

  always_comb begin
    duty_d = duty_q;
    if (up)      duty_d = (duty_q >= MAX_V - STEP_V) ? MAX_V : duty_q + STEP_V;
    else if (dn) duty_d = (duty_q < STEP_V) ? '0 : duty_q - STEP_V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_q <= '0;
    else        duty_q <= duty_d;
  end

  // ---------------- PWM ----------------
  logic [DIV_W-1:0]  div_q;
  logic              tick;
  logic [DUTY_W-1:0] cnt_q;
  logic              pwm_q;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) cnt_q <= (cnt_q == MAX_V - 1'b1) ? '0 : cnt_q + 1'b1;
      // Compared against live duty: a change applies mid-period.
      pwm_q <= en && (cnt_q < duty_q);
    end
  end

  assign pwm_out = pwm_q;

  // ---------------- BCD split + display ----------------
  logic              hund;
  logic [DUTY_W-1:0] rem;
  logic [3:0]        tens;
  logic [2:0][3:0]   bcd;
  logic [2:0]        blank;
  logic [2:0][6:0]   seg;

  assign hund = (duty_q >= MAX_V);
  assign rem  = hund ? duty_q - MAX_V : duty_q;
  assign tens = 4'(rem / DUTY_W'(10));

  assign bcd[2] = {3'b000, hund};
  assign bcd[1] = tens;
  assign bcd[0] = 4'(rem % DUTY_W'(10));

  assign blank[2] = ~en | ~hund;
  assign blank[1] = ~en | (~hund & (tens == 4'd0));
  assign blank[0] = ~en;

  for (genvar g = 0; g < 3; g++) begin : g_dig
    seg7_dec u_seg (
      .bcd_i   (bcd[g]),
      .blank_i (blank[g]),
      .seg_o   (seg[g])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
module tb_pwm_duty_ctrl;

`ifdef PWM_DEBOUNCE_EN
  localparam int HOLD = 24;
`else
  localparam int HOLD = 5;
`endif

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] SW;
  logic       pwm_out;
  logic [6:0] HEX0, HEX1, HEX2;

  int n_pass = 0;
  int n_tot  = 0;

  pwm_duty_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SW      (SW),
    .pwm_out (pwm_out),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sw;
    logic [6:0] h2, h1, h0;
    string      name;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic check_hex(input string name, input logic [6:0] e2, input logic [6:0] e1,
                           input logic [6:0] e0);
    check({name, ".HEX2"}, HEX2, e2);
    check({name, ".HEX1"}, HEX1, e1);
    check({name, ".HEX0"}, HEX0, e0);
  endtask

  // Apply SW for HOLD clocks, return at a falling edge for sampling.
  task automatic apply(input logic [2:0] sw);
    @(negedge clk);
    SW = sw;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [2:0] sw);
    apply(sw);
    apply(3'b001);
  endtask

  // Count high samples over one PWM period (CLK_DIV=1 -> 100 clk).
  task automatic pwm_count(input string name, input int exp);
    int hi;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    check(name, 7'(hi), 7'(exp));
  endtask

  initial begin
    tbl[0]  = '{3'b001, B, B,  D0, "en_on_0"};
    tbl[1]  = '{3'b011, B, D1, D0, "up_10"};
    tbl[2]  = '{3'b001, B, D1, D0, "rel_10"};
    tbl[3]  = '{3'b011, B, D2, D0, "up_20"};
    tbl[4]  = '{3'b001, B, D2, D0, "rel_20"};
    tbl[5]  = '{3'b101, B, D1, D0, "dn_10"};
    tbl[6]  = '{3'b001, B, D1, D0, "rel_dn"};
    tbl[7]  = '{3'b000, B, B,  B,  "dis_blank"};
    tbl[8]  = '{3'b010, B, B,  B,  "dis_up_ign"};
    tbl[9]  = '{3'b000, B, B,  B,  "dis_rel"};
    tbl[10] = '{3'b001, B, D1, D0, "en_restore"};
    tbl[11] = '{3'b111, B, D1, D0, "both_nochg"};
    tbl[12] = '{3'b001, B, D1, D0, "both_rel"};

    // T1 reset state
    SW    = 3'b000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_hex("rst", B, B, B);
    check("rst.pwm", {6'd0, pwm_out}, 7'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_hex("rst_rel", B, B, B);

    // T2/T3/T5/T6 vector table
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].sw);
      check_hex(tbl[i].name, tbl[i].h2, tbl[i].h1, tbl[i].h0);
      if (i == 2)  pwm_count("pwm_10", 10);
      if (i == 8)  pwm_count("pwm_dis", 0);
      if (i == 12) pwm_count("pwm_10b", 10);
    end

    // T4 saturate at 100
    for (int i = 0; i < 12; i++) press(3'b011);
    check_hex("sat100", D1, D0, D0);
    pwm_count("pwm_100", 100);

    // walk down to 0, then one more down stays at 0
    for (int i = 0; i < 10; i++) press(3'b101);
    check_hex("down0", B, B, D0);
    pwm_count("pwm_0", 0);
    press(3'b101);
    check_hex("floor0", B, B, D0);

    // T6 reset mid-PWM at duty 100
    for (int i = 0; i < 10; i++) press(3'b011);
    check_hex("back100", D1, D0, D0);
    check("pre_rst.pwm", {6'd0, pwm_out}, 7'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.pwm", {6'd0, pwm_out}, 7'd0);
    check_hex("mid_rst", B, B, B);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    check_hex("post_rst", B, B, D0);
    pwm_count("pwm_post_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
